// File: rtl/itm_trace_pkg.sv
// Shared widths, field offsets and FSM encoding for the ITM trace decompressor.
package itm_trace_pkg;

    localparam int DEF_TIMESTAMP_WIDTH   = 32;
    localparam int DEF_INSTR_COUNT_WIDTH = 8;
    localparam int PC_WIDTH              = 32;

    // Compressed message is {ts, start_addr, instr_cnt}; output entry is {ts, pc}.
    localparam int MSG_CNT_LSB = 0;
    localparam int OUT_PC_LSB  = 0;
    localparam int OUT_TS_LSB  = PC_WIDTH;

    function automatic int msg_addr_lsb(input int cnt_width);
        return MSG_CNT_LSB + cnt_width;
    endfunction

    function automatic int msg_ts_lsb(input int cnt_width);
        return msg_addr_lsb(cnt_width) + PC_WIDTH;
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } itm_state_e;

endpackage

// File: rtl/itm_trace_decomp_expander.sv
// PC/timestamp/remaining-count datapath of the ITM trace decompressor.
// ITM_DECOMP_TS_INC_EN: when defined, each successive entry's timestamp advances by one.
module itm_trace_decomp_expander
    import itm_trace_pkg::*;
#(
    parameter int TIMESTAMP_WIDTH   = DEF_TIMESTAMP_WIDTH,
    parameter int INSTR_COUNT_WIDTH = DEF_INSTR_COUNT_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                load,
    input  logic                                step,
    input  logic                                clear,
    input  logic [TIMESTAMP_WIDTH-1:0]          ld_ts,
    input  logic [PC_WIDTH-1:0]                 ld_pc,
    input  logic [INSTR_COUNT_WIDTH-1:0]        ld_cnt,
    output logic [TIMESTAMP_WIDTH+PC_WIDTH-1:0] trace_out,
    output logic                                trace_out_valid,
    output logic                                last
);

    logic [PC_WIDTH-1:0]          pc_r;
    logic [TIMESTAMP_WIDTH-1:0]   ts_r;
    logic [TIMESTAMP_WIDTH-1:0]   ts_next_s;
    logic [INSTR_COUNT_WIDTH-1:0] rem_r;
    logic                         valid_r;

`ifdef ITM_DECOMP_TS_INC_EN
    assign ts_next_s = ts_r + TIMESTAMP_WIDTH'(1);
`else
    assign ts_next_s = ts_r;
`endif

    // Current entry registers; held values are zeroed whenever no entry is present.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r    <= '0;
            ts_r    <= '0;
            rem_r   <= '0;
            valid_r <= 1'b0;
        end else if (load) begin
            pc_r    <= ld_pc;
            ts_r    <= ld_ts;
            rem_r   <= ld_cnt;
            valid_r <= 1'b1;
        end else if (step) begin
            pc_r    <= pc_r + 32'd4;
            ts_r    <= ts_next_s;
            rem_r   <= rem_r - INSTR_COUNT_WIDTH'(1);
            valid_r <= 1'b1;
        end else if (clear) begin
            pc_r    <= '0;
            ts_r    <= '0;
            rem_r   <= '0;
            valid_r <= 1'b0;
        end else begin
            pc_r    <= pc_r;
            ts_r    <= ts_r;
            rem_r   <= rem_r;
            valid_r <= valid_r;
        end
    end

    assign trace_out[OUT_PC_LSB +: PC_WIDTH]        = pc_r;
    assign trace_out[OUT_TS_LSB +: TIMESTAMP_WIDTH] = ts_r;
    assign trace_out_valid                          = valid_r;
    assign last                                     = (rem_r == INSTR_COUNT_WIDTH'(1));

endmodule

// File: rtl/itm_trace_decompression.sv
// ITM trace decompressor: expands {ts, start_addr, instr_cnt} into instr_cnt {ts, pc} entries.
// ITM_DECOMP_TS_INC_EN: when defined, entry i carries ts + i instead of the message ts.
module itm_trace_decompression
    import itm_trace_pkg::*;
#(
    parameter int TIMESTAMP_WIDTH   = DEF_TIMESTAMP_WIDTH,
    parameter int INSTR_COUNT_WIDTH = DEF_INSTR_COUNT_WIDTH
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [TIMESTAMP_WIDTH+PC_WIDTH+INSTR_COUNT_WIDTH-1:0] trace_in_compressed,
    input  logic                                                  trace_in_compressed_valid,
    output logic                                                  trace_in_compressed_ready,
    output logic [TIMESTAMP_WIDTH+PC_WIDTH-1:0]                   trace_out,
    output logic                                                  trace_out_valid,
    input  logic                                                  trace_out_ready,
    output logic                                                  busy,
    output logic                                                  err_zero_cnt
);

    localparam int MSG_ADDR_LSB = msg_addr_lsb(INSTR_COUNT_WIDTH);
    localparam int MSG_TS_LSB   = msg_ts_lsb(INSTR_COUNT_WIDTH);

    itm_state_e                   state_r;
    itm_state_e                   state_nxt_s;
    logic [INSTR_COUNT_WIDTH-1:0] in_cnt_s;
    logic [PC_WIDTH-1:0]          in_pc_s;
    logic [TIMESTAMP_WIDTH-1:0]   in_ts_s;
    logic                         ready_s;
    logic                         accept_s;
    logic                         xfer_s;
    logic                         zero_cnt_s;
    logic                         last_s;
    logic                         load_s;
    logic                         step_s;
    logic                         clear_s;
    logic                         busy_r;
    logic                         err_r;

    assign in_cnt_s   = trace_in_compressed[MSG_CNT_LSB  +: INSTR_COUNT_WIDTH];
    assign in_pc_s    = trace_in_compressed[MSG_ADDR_LSB +: PC_WIDTH];
    assign in_ts_s    = trace_in_compressed[MSG_TS_LSB   +: TIMESTAMP_WIDTH];
    assign zero_cnt_s = (in_cnt_s == '0);
    assign accept_s   = trace_in_compressed_valid && ready_s;
    assign xfer_s     = trace_out_valid && trace_out_ready;
    assign load_s     = accept_s && !zero_cnt_s;

    // Input-side ready: free in IDLE, or when the last entry leaves this cycle.
    always_comb begin
        ready_s = 1'b0;
        if (rst) begin
            ready_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:   ready_s = 1'b1;
                ST_EXPAND: ready_s = last_s && trace_out_ready;
                default:   ready_s = 1'b0;
            endcase
        end
    end

    // Next state and datapath control; a zero-count accept never leaves IDLE.
    always_comb begin
        state_nxt_s = state_r;
        step_s      = 1'b0;
        clear_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load_s) begin
                    state_nxt_s = ST_EXPAND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXPAND: begin
                if (xfer_s && last_s) begin
                    if (load_s) begin
                        state_nxt_s = ST_EXPAND;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        clear_s     = 1'b1;
                    end
                end else if (xfer_s) begin
                    state_nxt_s = ST_EXPAND;
                    step_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_EXPAND;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                clear_s     = 1'b1;
            end
        endcase
    end

    // State, busy flag and zero-count error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_EXPAND);
            err_r   <= accept_s && zero_cnt_s;
        end
    end

    itm_trace_decomp_expander #(
        .TIMESTAMP_WIDTH   (TIMESTAMP_WIDTH),
        .INSTR_COUNT_WIDTH (INSTR_COUNT_WIDTH)
    ) u_expander (
        .clk             (clk),
        .rst             (rst),
        .load            (load_s),
        .step            (step_s),
        .clear           (clear_s),
        .ld_ts           (in_ts_s),
        .ld_pc           (in_pc_s),
        .ld_cnt          (in_cnt_s),
        .trace_out       (trace_out),
        .trace_out_valid (trace_out_valid),
        .last            (last_s)
    );

    assign trace_in_compressed_ready = ready_s;
    assign busy                      = busy_r;
    assign err_zero_cnt              = err_r;

endmodule

// File: doc/itm_trace_decompression.md
ITM_TRACE_DECOMPRESSION -- requirements
Module: itm_trace_decompression

Interface
REQ-001 The block SHALL have parameter TIMESTAMP_WIDTH, default 32: width of the timestamp field.
REQ-002 The block SHALL have parameter INSTR_COUNT_WIDTH, default 8: width of the instruction-count field.
REQ-003 Port clk  input  1: clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port trace_in_compressed  input  TIMESTAMP_WIDTH+32+INSTR_COUNT_WIDTH: packed message {ts, start_addr, instr_cnt}, with ts in the MSBs and instr_cnt in the LSBs.
REQ-006 Port trace_in_compressed_valid  input  1: message present.
REQ-007 Port trace_in_compressed_ready  output  1: block accepts the message this cycle.
REQ-008 Port trace_out  output  TIMESTAMP_WIDTH+32: expanded entry {ts, pc}, with ts in the MSBs and pc in bits [31:0].
REQ-009 Port trace_out_valid  output  1: entry present.
REQ-010 Port trace_out_ready  input  1: sink accepts the entry.
REQ-011 Port busy  output  1: high while in EXPAND.
REQ-012 Port err_zero_cnt  output  1: one-cycle pulse when a message with instr_cnt==0 is consumed.

Function
REQ-013 A message transfers when trace_in_compressed_valid and trace_in_compressed_ready are both high; an output entry transfers when trace_out_valid and trace_out_ready are both high.
REQ-014 FSM states: IDLE and EXPAND; the block SHALL be in IDLE after reset.
REQ-015 trace_in_compressed_ready = (state==IDLE) OR (state==EXPAND AND current entry is the last AND trace_out_ready); this is the only combinational path, and all other outputs are registered.
REQ-016 A message with instr_cnt=N>0 SHALL produce exactly N output entries, in order; entry i (0..N-1) has pc = start_addr + 4*i, computed modulo 2^32 (so 0xFFFFFFFC wraps to 0x00000000).
REQ-017 Latency: for a message accepted in cycle C, entry 0 SHALL be valid in cycle C+1.
REQ-018 Output rate: one entry per cycle while trace_out_ready is high; no bubble between the last entry of one message and entry 0 of a back-to-back next message.
REQ-019 While trace_out_valid is high and trace_out_ready is low, trace_out SHALL hold stable.
REQ-020 A remaining-count register SHALL load N on accept and decrement on each output transfer; when the transfer of the last entry coincides with no new accept, state SHALL return to IDLE.
REQ-021 A message with instr_cnt==0 SHALL be consumed in one cycle with no output entry, SHALL pulse err_zero_cnt in cycle C+1, and SHALL leave the FSM in IDLE.
REQ-022 trace_out SHALL be 0 whenever trace_out_valid is low.
REQ-023 The block SHALL not reconstruct repeated-PC (stall) entries; every expanded entry advances pc by 4.

Reset
REQ-024 On rst the following SHALL be cleared to 0: state (IDLE), trace_out, trace_out_valid, busy, err_zero_cnt, the remaining-count register and the held ts/pc.
REQ-025 Reset mid-EXPAND SHALL discard the remainder of the message with no further entries.
REQ-026 trace_in_compressed_ready SHALL be 0 while rst is high.

Configuration
REQ-027 The macro ITM_DECOMP_TS_INC_EN SHALL select timestamp behaviour.
REQ-028 With ITM_DECOMP_TS_INC_EN defined, entry i SHALL carry ts + i, computed modulo 2^TIMESTAMP_WIDTH.
REQ-029 Without ITM_DECOMP_TS_INC_EN, every entry of a message SHALL carry the message ts unchanged.

Structure
REQ-030 Package itm_trace_pkg SHALL hold the default widths, the field offsets of the compressed message and output entry, and the FSM state enum.
REQ-031 Sub-module itm_trace_decomp_expander SHALL hold the pc/ts/count datapath, with the handshake FSM kept in the top module.
REQ-032 The RTL SHALL be 120-400 lines.

Verification
REQ-033 Accept {ts=0x10, sa=0x100, cnt=3} with trace_out_ready=1: entries pc 0x100, 0x104, 0x108 in cycles C+1..C+3, each with ts=0x10 (ts 0x10, 0x11, 0x12 with the macro defined), and busy high over the same cycles.
REQ-034 Back-to-back {sa=0x200, cnt=2} then {sa=0x800, cnt=1}: pc 0x200, 0x204, 0x800 on consecutive cycles, with ready high on the last-entry cycle.
REQ-035 Backpressure: trace_out_ready=0 for 4 cycles during entry 1 of {sa=0x40, cnt=3}: pc 0x44 stays stable, then 0x48 follows; total 3 entries.
REQ-036 Zero count: accept {cnt=0}: no trace_out_valid, err_zero_cnt=1 for exactly one cycle, FSM in IDLE and ready=1 the next cycle.
REQ-037 Wrap and reset: {sa=0xFFFFFFF8, cnt=3} gives pc 0xFFFFFFF8, 0xFFFFFFFC, 0x0; then rst asserted after entry 1 of {cnt=200} gives all outputs 0 and no further entries.
